// File: rtl/aes_inv_round_ctrl_if.sv
// Ciphertext-in / plaintext-out valid/ready bus of the AES inverse-round sequencer.
interface aes_inv_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
endinterface

// File: rtl/aes_inv_round_ctrl.sv
// AES-128 decryption sequencer around an external combinational inverse-round datapath.
// Optional macro AES_INV_ABORT_EN adds abort_i, which drops an in-flight block back to IDLE.
module aes_inv_round_ctrl #(
  parameter int NR  = 10,
  parameter int KIW = 4
) (
  input  logic                clk,
  input  logic                rst,
  aes_inv_round_ctrl_if.slave bus,
  output logic [KIW-1:0]      key_idx_o,
  input  logic [127:0]        key_data_i,
  output logic [127:0]        rnd_state_o,
  output logic [127:0]        rnd_key_o,
  output logic                rnd_last_o,
  input  logic [127:0]        rnd_result_i,
`ifdef AES_INV_ABORT_EN
  input  logic                abort_i,
`endif
  output logic                busy_o
);
  localparam logic [KIW-1:0] NR_K = KIW'(NR);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_ROUND, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [127:0]   st_q, st_d;
  logic [KIW-1:0] rcnt_q, rcnt_d;
  logic           kill;

`ifdef AES_INV_ABORT_EN
  assign kill = abort_i && (state_q != S_IDLE);
`else
  assign kill = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      S_IDLE: if (bus.in_valid) begin
        st_d    = bus.in_data;
        state_d = S_INIT;
      end
      S_INIT: begin
        st_d    = st_q ^ key_data_i;
        rcnt_d  = KIW'(1);
        state_d = S_ROUND;
      end
      S_ROUND: begin
        st_d = rnd_result_i;
        if (rcnt_q == NR_K) state_d = S_DONE;
        else                rcnt_d  = rcnt_q + 1'b1;
      end
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // abort discards the block entirely, including the partial state
    if (kill) begin
      state_d = S_IDLE;
      st_d    = '0;
      rcnt_d  = '0;
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
    busy_o        = (state_q != S_IDLE);
    key_idx_o     = NR_K;
    rnd_last_o    = 1'b0;
    if (state_q == S_ROUND) begin
      key_idx_o  = NR_K - rcnt_q;
      rnd_last_o = (rcnt_q == NR_K);
    end
  end

  assign bus.out_data = st_q;
  assign rnd_state_o  = st_q;
  assign rnd_key_o    = key_data_i;
endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench: FIPS-197 key store + inverse-round model around the sequencer, scoreboard on the plaintext port.
module tb_aes_inv_round_ctrl;
  localparam logic [127:0] KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

  logic         clk, rst;
  logic [3:0]   key_idx;
  logic [127:0] key_data, rnd_state, rnd_key, rnd_result;
  logic         rnd_last, busy;
`ifdef AES_INV_ABORT_EN
  logic         abort;
`endif

  aes_inv_round_ctrl_if bus();

  aes_inv_round_ctrl #(.NR(10), .KIW(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .key_idx_o(key_idx), .key_data_i(key_data),
    .rnd_state_o(rnd_state), .rnd_key_o(rnd_key), .rnd_last_o(rnd_last),
    .rnd_result_i(rnd_result),
`ifdef AES_INV_ABORT_EN
    .abort_i(abort),
`endif
    .busy_o(busy)
  );

  int total = 0, bad = 0, cyc_cnt = 0, ov_cnt = 0, last_acc = 0;
  logic [127:0] exp_q[$];
  logic [127:0] rk [0:15];
  logic [31:0]  w [0:43];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---- GF(2^8) / AES helpers ----
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (and maps 0 to 0)
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r = 8'h01, b = a;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) r = gmul(r, b);
      b = gmul(b, b);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b = ginv(a);
    return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] a);
    return ginv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] mixcols(input logic [127:0] s, input bit inv);
    logic [7:0] m[4], x[4], y;
    logic [127:0] r = '0;
    if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
    else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) x[k] = s[127-8*(4*c+k) -: 8];
      for (int j = 0; j < 4; j++) begin
        y = 8'h00;
        for (int k = 0; k < 4; k++) y ^= gmul(m[(k-j+4)%4], x[k]);
        r[127-8*(4*c+j) -: 8] = y;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [7:0] t[16];
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        t[4*((c+rr)%4)+rr] = isbox(s[127-8*(4*c+rr) -: 8]);
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    r ^= k;
    if (!last) r = mixcols(r, 1'b1);
    return r;
  endfunction

  // Forward cipher gives an independent reference for random plaintexts.
  function automatic logic [127:0] enc(input logic [127:0] p);
    logic [127:0] s = p ^ rk[0], r;
    for (int n = 1; n <= 10; n++) begin
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          r[127-8*(4*c+rr) -: 8] = sbox(s[127-8*(4*((c+rr)%4)+rr) -: 8]);
      if (n != 10) r = mixcols(r, 1'b0);
      s = r ^ rk[n];
    end
    return s;
  endfunction

  // ---- key store and datapath models ----
  always_comb key_data = rk[key_idx];
  always_comb rnd_result = inv_round(rnd_state, rnd_key, rnd_last);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (bus.out_valid) ov_cnt <= ov_cnt + 1;
    if (bus.out_valid && bus.out_ready) begin
      chk("sb_avail", 128'(exp_q.size() > 0), 128'd1);
      if (exp_q.size() > 0) chk("sb_data", bus.out_data, exp_q.pop_front());
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [127:0] ct, input logic [127:0] pt, input bit keep);
    bit acc = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = ct;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.in_ready && !rst) begin
        exp_q.push_back(pt);
        last_acc = cyc_cnt;
        acc = 1;
        break;
      end
    end
    chk("accept_timeout", 128'(acc), 128'd1);
    tick();
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic wait_ov(input int bound);
    bit seen = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin seen = 1; break; end
    end
    chk("ov_timeout", 128'(seen), 128'd1);
  endtask

  task automatic wait_key(input logic [3:0] k);
    bit hit = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy && key_idx == k) begin hit = 1; break; end
    end
    chk("key_hit", 128'(hit), 128'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  128'(bus.in_ready),  128'd1);
    chk({tag, "_busy"},      128'(busy),          128'd0);
    chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'd0);
    chk({tag, "_last"},      128'(rnd_last),      128'd0);
    chk({tag, "_key_idx"},   128'(key_idx),       128'd10);
    chk({tag, "_state"},     rnd_state,           128'd0);
  endtask

  task automatic drop_and_quiet(input string tag);
    int ovb;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    ovb = ov_cnt;
    repeat (15) tick();
    chk({tag, "_no_ov"}, 128'(ov_cnt - ovb), 128'd0);
  endtask

  initial begin
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] p1, p2, c1, c2;
    int lat, a1;

    for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 16; r++) rk[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;

    // reset with a block offered at the same time: nothing may be captured
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = CT; bus.out_ready = 1'b1;
`ifdef AES_INV_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) tick();
    chk_idle("rst");
    chk("key10", rk[10], KEY10);
    chk("enc_ref", enc(PT), CT);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk_idle("post_rst");

    // FIPS-197 C.1; n counts sampled cycles after the acceptance cycle
    send(CT, PT, 1'b0);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n <= 12) begin
        chk("seq_key",  128'(key_idx),  128'((n == 1 || n == 12) ? 10 : 11 - n));
        chk("seq_last", 128'(rnd_last), 128'(n == 11));
      end
      if (n == 5) begin
        chk("mid_busy",     128'(busy),         128'd1);
        chk("mid_in_ready", 128'(bus.in_ready), 128'd0);
      end
      if (bus.out_valid) begin lat = n; break; end
    end
    chk("latency", 128'(lat), 128'd12);
    tick();
    chk("fips_back_idle", 128'(bus.in_ready), 128'd1);

    // backpressure with ignored in_valid pulses
    p1 = {$urandom, $urandom, $urandom, $urandom};
    c1 = enc(p1);
    bus.out_ready = 1'b0;
    send(c1, p1, 1'b0);
    wait_ov(40);
    for (int i = 0; i < 20; i++) begin
      tick();
      bus.in_valid = i[0];
      bus.in_data  = ~c1;
      @(negedge clk);
      chk("bp_valid",    128'(bus.out_valid), 128'd1);
      chk("bp_data",     bus.out_data,        p1);
      chk("bp_in_ready", 128'(bus.in_ready),  128'd0);
    end
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp_rel_ready", 128'(bus.in_ready),  128'd1);
    chk("bp_rel_valid", 128'(bus.out_valid), 128'd0);

    // back-to-back with in_valid held high
    p1 = {$urandom, $urandom, $urandom, $urandom};
    p2 = {$urandom, $urandom, $urandom, $urandom};
    c1 = enc(p1);
    c2 = enc(p2);
    send(c1, p1, 1'b1);
    a1 = last_acc;
    send(c2, p2, 1'b0);
    chk("b2b_gap", 128'(last_acc - a1), 128'd13);
    wait_ov(40);
    tick();

    // reset in the middle of ROUND (rcnt=5 -> key 5)
    send(CT, PT, 1'b0);
    wait_key(4'd5);
    rst = 1'b1;
    tick();
    chk_idle("rst_mid");
    rst = 1'b0;
    drop_and_quiet("rst_mid");
    send(CT, PT, 1'b0);
    wait_ov(40);
    tick();

`ifdef AES_INV_ABORT_EN
    // abort at rcnt=3 -> key 7
    send(CT, PT, 1'b0);
    wait_key(4'd7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort");
    drop_and_quiet("abort");

    // abort in IDLE does not block the handshake
    abort = 1'b1;
    send(CT, PT, 1'b0);
    abort = 1'b0;
    chk("abort_idle_busy", 128'(busy), 128'd1);
    wait_ov(40);
    tick();

    // rst and abort together
    p1 = {$urandom, $urandom, $urandom, $urandom};
    send(enc(p1), p1, 1'b0);
    repeat (4) tick();
    abort = 1'b1;
    rst   = 1'b1;
    tick();
    chk_idle("abort_rst");
    abort = 1'b0;
    rst   = 1'b0;
    drop_and_quiet("abort_rst");
`endif

    repeat (3) tick();
    chk("sb_left", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
